// File: rtl/countdown_timer_gen2.sv
// countdown_timer_gen2: single-channel countdown timer feeding the 7-segment driver.
//
// A count is loaded from the register interface and decremented once every
// TICKS_PER_UNIT clocks while running. A synchronised start/stop button toggles
// running. One-shot or auto-reload behaviour is selected at expiry, and a
// one-cycle pulse marks each expiry.
//
// Optional feature macro: COUNTDOWN_BCD_COUNT_EN
//   defined   - count holds WIDTH/4 packed BCD digits, decrements with decimal
//               borrow, and load nibbles above 9 are clamped to 9.
//   undefined - plain binary count, load_value taken as-is.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   load         synchronous load strobe
//   load_value   value captured on load
//   start_btn    raw start/stop button level (asynchronous to clk)
//   mode_reload  0 = one-shot, 1 = auto-reload (sampled at expiry)
//   count        current count
//   running      timer running
//   done         high while count == 0
//   expired      one-cycle pulse after reaching 0

module countdown_timer_gen2 #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned TICKS_PER_UNIT = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start_btn,
  input  logic             mode_reload,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             done,
  output logic             expired
);

  localparam int unsigned PW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [PW-1:0] TickLast = PW'(TICKS_PER_UNIT - 1);
  localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

`ifdef COUNTDOWN_BCD_COUNT_EN
  // Clamp every nibble to a legal decimal digit.
  function automatic logic [WIDTH-1:0] bcd_clamp(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = v;
    for (int i = 0; i < int'(WIDTH / 4); i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Decrement by one with decimal borrow ripple from the least significant digit.
  function automatic logic [WIDTH-1:0] bcd_dec(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    logic             borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < int'(WIDTH / 4); i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction
`endif

  // Button synchroniser, edge history and registered rise detect.
  logic sync1_q, sync2_q, sync3_q, rise_q;
  logic rise_d;

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             running_q, running_d;
  logic             expired_q, expired_d;

  logic [WIDTH-1:0] load_eff;
  logic [WIDTH-1:0] count_dec;
  logic             tick;

`ifdef COUNTDOWN_BCD_COUNT_EN
  assign load_eff  = bcd_clamp(load_value);
  assign count_dec = bcd_dec(count_q);
`else
  assign load_eff  = load_value;
  assign count_dec = count_q - One;
`endif

  assign rise_d = sync2_q & ~sync3_q;
  assign tick   = running_q && (presc_q == TickLast);

  always_comb begin
    count_d   = count_q;
    reload_d  = reload_q;
    running_d = running_q;
    expired_d = 1'b0;

    // Prescaler only advances while running; a tick wraps it back to zero.
    if (!running_q || load || tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    if (load) begin
      // Load wins over a same-cycle tick; the tick is simply dropped.
      count_d  = load_eff;
      reload_d = load_eff;
      if (rise_q) begin
        running_d = running_q ? 1'b0 : (load_eff != '0);
      end else if (load_eff == '0) begin
        running_d = 1'b0;
      end
    end else begin
      if (tick) begin
        if (count_q > One) begin
          count_d = count_dec;
        end else if (count_q == One) begin
          expired_d = 1'b1;
          if (mode_reload && (reload_q != '0)) begin
            count_d = reload_q;
          end else begin
            count_d   = '0;
            running_d = 1'b0;
          end
        end
      end
      // A stop arriving with a tick still lets the tick (and any reload) land.
      if (rise_q) begin
        running_d = running_q ? 1'b0 : (count_q != '0);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      rise_q    <= 1'b0;
      count_q   <= '0;
      reload_q  <= '0;
      presc_q   <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      sync1_q   <= start_btn;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      rise_q    <= rise_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      expired_q <= expired_d;
    end
  end

  assign count   = count_q;
  assign running = running_q;
  assign expired = expired_q;
  assign done    = (count_q == '0);

endmodule
